// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions used by the receive and transmit
//               sides: FSM state encodings and the data-bits-per-frame count.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/sync2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync2ff
// Description : Two-flop synchronizer for a single asynchronous input bit.
//               Both flops reset to RST_VAL so the output shows the line's
//               idle level straight out of reset.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset
//               d_i  - asynchronous input
//               q_o  - synchronized output (2 clocks of latency)
// Revision    : 1.0  initial release
// ============================================================================
module sync2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_8n1
// Description : UART 8N1 receiver. Synchronizes rx, detects the start edge,
//               samples each bit mid-period using an internal bit-period
//               counter and delivers each good byte with a one-cycle strobe.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous active-high reset
//               rx          - serial line, idle high, asynchronous
//               rxbyte      - last correctly framed byte (LSB first on line)
//               rxdone      - one-cycle pulse when rxbyte is updated
//               framing_err - level, last frame had a low stop bit
//               busy        - high whenever the receiver is not idle
// Options     : UART_RX_MAJORITY_EN - when defined, every bit sample is the
//               2-of-3 majority of the synchronized line over the sample
//               cycle and the two cycles before it.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int              SIZE  = 10,
  parameter logic [SIZE-1:0] LIMIT = 10'd625
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxdone,
  output logic       framing_err,
  output logic       busy
);

  localparam logic [SIZE-1:0] CNT_ONE  = SIZE'(1);
  // Start bit is checked half a period in so later samples land mid-bit.
  localparam logic [SIZE-1:0] HALF_END = (LIMIT >> 1) - CNT_ONE;
  localparam logic [SIZE-1:0] BIT_END  = LIMIT - CNT_ONE;
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  logic rxs;
  logic sample;

  sync2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous rxs values; together with the current rxs they form the
  // three-cycle window voted on at each sample point.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxs};
    end
  end

  assign sample = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rxs;
`endif

  uart_state_e          state_q, state_d;
  logic [SIZE-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           rxbyte_q, rxbyte_d;
  logic                 rxdone_q, rxdone_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rxbyte_q <= 8'h00;
      rxdone_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rxbyte_q <= rxbyte_d;
      rxdone_q <= rxdone_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rxbyte_d = rxbyte_q;
    rxdone_d = 1'b0;
    ferr_d   = ferr_q;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
          ferr_d  = 1'b0;
        end
      end

      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (!sample) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (sample) begin
            rxbyte_d = shift_q;
            rxdone_d = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start
        // edge can be recognised.
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rxbyte      = rxbyte_q;
  assign rxdone      = rxdone_q;
  assign framing_err = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire
